// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_ALIGN_CHECK_EN adds the ERROR state used by the misaligned-target trap.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;
`endif

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential PC+4 or branch target PC+ImmOp.
// Kept standalone so the pipelined core can reuse it.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             PCsrc,
  output logic [WIDTH-1:0] pc_next
);

  // Modulo-2^WIDTH arithmetic; wrap past the top of the address space is intended.
  assign pc_next = PCsrc ? (PC + ImmOp) : (PC + WIDTH'(INSTR_BYTES));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one-outstanding word reads, valid/ready hand-off to decode.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned next-PC targets in an ERROR state.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic             fetch_err,
`endif
  output logic [WIDTH-1:0] PC
);

  fetch_state_t     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_instr_valid;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_handshake;
`ifdef FETCH_ALIGN_CHECK_EN
  logic             r_fetch_err;
`endif

  pc_next_sel #(
    .WIDTH (WIDTH)
  ) u_pc_next_sel (
    .PC      (r_pc),
    .ImmOp   (ImmOp),
    .PCsrc   (PCsrc),
    .pc_next (w_pc_next)
  );

  assign w_handshake = r_instr_valid && instr_ready;

  // Request strobe decodes the FETCH state so it appears the cycle after reset or a handshake.
  assign mem_req     = (r_state == ST_FETCH) && !rst;
  assign mem_addr    = r_pc;
  assign PC          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_err   = r_fetch_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_fetch_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_instr       <= mem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            r_pc          <= w_pc_next;
            r_instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_pc_next[1:0] != 2'b00) begin
              r_state     <= ST_ERROR;
              r_fetch_err <= 1'b1;
            end else begin
              r_state     <= ST_FETCH;
            end
`else
            r_state       <= ST_FETCH;
`endif
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_ERROR: r_state <= ST_ERROR;
`endif
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: request addresses and captured words are
// predicted by a reference PC model and checked as the DUT produces them.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic [31:0] PC;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  instr_fetch_unit #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_err   (fetch_err),
`endif
    .PC          (PC)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_err;
  bit          prev_valid;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          inj_rvalid;
  bit          ready_en;
  bit          rand_ready;
  bit          rand_lat;
  bit          chk_int;
  bit          br_en;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  int          cyc_n;
  int          last_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc_n);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // One clock: drive inputs 1 time unit after the edge, sample and score 1 unit later.
  task automatic cyc(input bit r);
    bit          resp;
    logic [31:0] rd;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    rst        = r;
    resp       = 1'b0;
    rd         = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        resp       = 1'b1;
        pend       = 1'b0;
        rd         = memf(pend_addr);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        if (!r) exp_instr.push_back(rd);
      end
    end else if (inj_rvalid) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      inj_rvalid = 1'b0;
    end
    instr_ready = ready_en ? 1'b1 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b0);
    if (m_valid && instr_ready && br_en && m_pc == br_pc) begin
      PCsrc = 1'b1;
      ImmOp = br_imm;
    end else if (m_valid && instr_ready) begin
      PCsrc = 1'b0;
      ImmOp = $urandom;
    end else begin
      PCsrc = 1'($urandom_range(0, 1));
      ImmOp = $urandom;
    end
    #1;
    cyc_n++;
    if (r) begin
      m_pc       = RST_PC;
      m_valid    = 1'b0;
      m_err      = 1'b0;
      m_instr    = '0;
      prev_valid = 1'b0;
      pend       = 1'b0;
      last_req   = -1;
      exp_addr.delete();
      exp_instr.delete();
      exp_addr.push_back(RST_PC);
      return;
    end
    chk("pc", PC, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) chk("instr_hold", instr, m_instr);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
`endif
    if (mem_req) begin
      if (exp_addr.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
      else chk("req_addr", mem_addr, exp_addr.pop_front());
      if (chk_int && last_req >= 0) chk("req_interval", 32'(cyc_n - last_req), 32'd3);
      last_req  = cyc_n;
      pend      = 1'b1;
      pend_cnt  = rand_lat ? $urandom_range(1, 3) : 1;
      pend_addr = mem_addr;
    end
    if (instr_valid && !prev_valid) begin
      if (exp_instr.size() == 0) chk("unexpected_instr", 32'(instr_valid), 32'd0);
      else chk("instr_sb", instr, exp_instr.pop_front());
    end
    prev_valid = instr_valid;
    if (m_valid && instr_ready) begin
      nxt     = PCsrc ? (m_pc + ImmOp) : (m_pc + 32'd4);
      m_pc    = nxt;
      m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (nxt[1:0] != 2'b00) m_err = 1'b1;
      else exp_addr.push_back(nxt);
`else
      exp_addr.push_back(nxt);
`endif
    end
    if (resp && !r) begin
      m_valid = 1'b1;
      m_instr = rd;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1);
    cyc(1'b1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc", PC, RST_PC);
    chk("rst_addr", mem_addr, RST_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_err", 32'(fetch_err), 32'd0);
`endif
  endtask

  initial begin
    bit found;
    rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    pend = 0; inj_rvalid = 0; ready_en = 1; rand_ready = 0; rand_lat = 0;
    chk_int = 0; br_en = 0; br_pc = '0; br_imm = '0; cyc_n = 0; last_req = -1;
    m_pc = RST_PC; m_valid = 0; m_err = 0; m_instr = '0; prev_valid = 0;

    // Reset-release latency and first word
    do_reset();
    cyc(1'b0);
    chk("n1_req", 32'(mem_req), 32'd1);
    chk("n1_addr", mem_addr, 32'd0);
    cyc(1'b0);
    chk("n2_valid", 32'(instr_valid), 32'd0);
    cyc(1'b0);
    chk("n3_valid", 32'(instr_valid), 32'd1);
    chk("n3_instr", instr, 32'h0000_0013);

    // Sequential run, ready tied high
    chk_int = 1;
    repeat (12) cyc(1'b0);

    // Backward branch at 0x10 by -8
    do_reset();
    br_en = 1; br_pc = 32'h10; br_imm = 32'hFFFF_FFF8;
    repeat (30) cyc(1'b0);
    br_en = 0; chk_int = 0;

    // Backpressure in HOLD with a spurious response
    do_reset();
    ready_en = 0;
    for (int i = 0; i < 10 && !m_valid; i++) cyc(1'b0);
    if (!m_valid) chk("bp_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) inj_rvalid = 1;
      cyc(1'b0);
      chk("bp_no_req", 32'(mem_req), 32'd0);
      chk("bp_instr", instr, 32'h0000_0013);
    end
    ready_en = 1;
    repeat (6) cyc(1'b0);

    // Reset in WAIT coinciding with the response
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0);
      if (mem_req && mem_addr != RST_PC) found = 1;
    end
    if (!found) chk("rstw_timeout", 32'd0, 32'd1);
    cyc(1'b1);
    cyc(1'b0);
    chk("rstw_valid", 32'(instr_valid), 32'd0);
    chk("rstw_pc", PC, RST_PC);
    chk("rstw_req", 32'(mem_req), 32'd1);
    repeat (2) cyc(1'b0);
    chk("rstw_instr_valid", 32'(instr_valid), 32'd1);
    chk("rstw_instr", instr, 32'h0000_0013);

    // Random ready and latency, looping across the address wrap
    do_reset();
    ready_en = 0; rand_ready = 1; rand_lat = 1;
    br_en = 1; br_pc = 32'h0; br_imm = 32'hFFFF_FFFC;
    repeat (150) cyc(1'b0);
    ready_en = 1; rand_ready = 0; rand_lat = 0; br_en = 0;

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned branch target traps
    do_reset();
    br_en = 1; br_pc = 32'h0; br_imm = 32'h2;
    repeat (12) cyc(1'b0);
    chk("align_err", 32'(fetch_err), 32'd1);
    chk("align_pc", PC, 32'h2);
    chk("align_no_req", 32'(mem_req), 32'd0);
    br_en = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
